// File: rtl/sm83_mcycle_bus.sv
// sm83 M-cycle bus sequencer: one core request -> one T_PER_M-state machine cycle
// with wait-state extension, timeout and back-to-back issue.
module sm83_mcycle_bus #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int T_PER_M  = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_idle,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_timeout,
    output logic              m_tick,
    output logic [3:0]        t_state,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    generate
        if (T_PER_M < 3 || T_PER_M > 16) begin : g_bad_t_per_m
            $error("sm83_mcycle_bus: T_PER_M must be 3..16");
        end
        if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
            $error("sm83_mcycle_bus: MAX_WAIT must be 1..255");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_WAIT
    } state_t;

    localparam logic [3:0] T_LAST = 4'(T_PER_M - 1);
    localparam logic [7:0] W_MAX  = 8'(MAX_WAIT);

    state_t            state, n_state;
    logic [3:0]        t_cnt, n_t;
    logic [7:0]        wcnt;
    logic              op_write;
    logic              op_idle;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic last_t;
    logic done_ok;
    logic tmo;
    logic ends;
    logic accept;
    logic strobe_n;

    always_comb begin
        last_t  = (state == S_RUN && t_cnt == T_LAST) || state == S_WAIT;
        done_ok = last_t && (op_idle || mem_ready);
        // idle cycles never enter WAIT, so only bus cycles can time out
        tmo     = state == S_WAIT && !mem_ready && wcnt == W_MAX;
        ends    = done_ok || tmo;
        req_ready = !rst && (state == S_IDLE || ends);
        accept  = req_valid && req_ready;
    end

    always_comb begin
        n_state = state;
        n_t     = t_cnt;
        if (accept) begin
            n_state = S_RUN;
            n_t     = 4'd0;
        end else if (ends) begin
            n_state = S_IDLE;
            n_t     = 4'd0;
        end else if (state == S_RUN && !last_t) begin
            n_t     = t_cnt + 4'd1;
        end else if (last_t) begin
            n_state = S_WAIT;
        end
    end

    // strobes are registered from the next T-state; on accept n_t is 0
    assign strobe_n = n_state == S_RUN && n_t != 4'd0 && n_t != T_LAST && !op_idle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            t_cnt       <= 4'd0;
            wcnt        <= 8'd0;
            op_write    <= 1'b0;
            op_idle     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid   <= 1'b0;
            m_tick      <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
        end else begin
            state       <= n_state;
            t_cnt       <= n_t;
            rsp_valid   <= ends;
            m_tick      <= ends;
            rsp_timeout <= tmo;
            mem_rd      <= strobe_n && !op_write;
            mem_wr      <= strobe_n && op_write;

            if (ends) begin
                wcnt <= 8'd0;
            end else if (last_t && !mem_ready) begin
                wcnt <= wcnt + 8'd1;
            end

            if (tmo) begin
                rsp_rdata <= '1;
            end else if (done_ok && !op_idle && !op_write) begin
                rsp_rdata <= mem_rdata;
            end

            if (accept) begin
                op_write <= req_write && !req_idle;
                op_idle  <= req_idle;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
        end
    end

    assign t_state   = t_cnt;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_sm83_mcycle_bus.sv
// Directed bench for sm83_mcycle_bus: scoreboard of expected responses
// plus in-cycle strobe/address checks.
module tb_sm83_mcycle_bus;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_idle;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_timeout;
    logic        m_tick;
    logic [3:0]  t_state;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_ready;
    logic [7:0]  mem_rdata;

    sm83_mcycle_bus #(
        .ADDR_W(16), .DATA_W(8), .T_PER_M(4), .MAX_WAIT(15)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_idle(req_idle),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_timeout(rsp_timeout), .m_tick(m_tick),
        .t_state(t_state),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        bit         rd;
        logic [7:0] data;
        bit         to;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // response side of the scoreboard
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            exp_t e;
            chk("rsp_pending", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rsp_cycle", cyc, e.cyc);
                chk("rsp_timeout", rsp_timeout, e.to);
                chk("m_tick", m_tick, 1);
                if (e.rd) chk("rsp_rdata", rsp_rdata, e.data);
            end
        end
    end

    task automatic issue(input bit wr, input bit idl, input logic [15:0] a,
                         input logic [7:0] d, input int lat, input bit rd,
                         input logic [7:0] rdat, input bit to, input bit push,
                         output int kacc);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_idle  = idl;
        req_addr  = a;
        req_wdata = d;
        kacc = -1;
        for (int i = 0; i < 40 && kacc < 0; i++) begin
            @(posedge clk);
            if (req_ready) begin
                kacc = cyc;
                if (push) sb.push_back(exp_t'{kacc + lat, rd, rdat, to});
            end
        end
        chk("accepted", 32'(kacc >= 0), 1);
    endtask

    task automatic drain();
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 60 && sb.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        chk("drained", sb.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, k1, k2, k3;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_idle  = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        mem_ready = 1'b1;
        mem_rdata = 8'h00;

        repeat (2) @(negedge clk);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_t_state", t_state, 0);
        rst = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_timeout", rsp_timeout, 0);

        // plain read
        mem_rdata = 8'h5A;
        issue(0, 0, 16'hC000, 8'h00, 5, 1, 8'h5A, 0, 1, k);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) req_valid = 1'b0;
            chk("rd_t_state", t_state, i - 1);
            chk("rd_mem_rd", mem_rd, 32'(i == 2 || i == 3));
            chk("rd_mem_wr", mem_wr, 0);
            chk("rd_mem_addr", mem_addr, 16'hC000);
        end
        drain();

        // plain write
        issue(1, 0, 16'hFF40, 8'h91, 5, 0, 8'h00, 0, 1, k);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) req_valid = 1'b0;
            chk("wr_mem_wr", mem_wr, 32'(i == 2 || i == 3));
            chk("wr_mem_rd", mem_rd, 0);
            chk("wr_mem_addr", mem_addr, 16'hFF40);
            chk("wr_mem_wdata", mem_wdata, 8'h91);
        end
        drain();

        // three wait states, data taken only when ready
        mem_ready = 1'b0;
        mem_rdata = 8'hEE;
        issue(0, 0, 16'h8000, 8'h00, 8, 1, 8'h3C, 0, 1, k);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            if (i == 1) req_valid = 1'b0;
            if (i >= 4) begin
                chk("wait_t_state", t_state, 3);
                chk("wait_mem_rd", mem_rd, 0);
            end
            if (i == 7) begin
                mem_ready = 1'b1;
                mem_rdata = 8'h3C;
            end
        end
        drain();

        // timeout after MAX_WAIT wait states
        mem_ready = 1'b0;
        mem_rdata = 8'h11;
        issue(0, 0, 16'h9000, 8'h00, 20, 1, 8'hFF, 1, 1, k);
        drain();
        mem_ready = 1'b1;
        @(negedge clk);
        chk("post_to_timeout", rsp_timeout, 0);
        chk("post_to_valid", rsp_valid, 0);

        // back-to-back idle, read, write
        mem_rdata = 8'hA5;
        issue(0, 1, 16'h0000, 8'h00, 5, 0, 8'h00, 0, 1, k1);
        issue(0, 0, 16'h1234, 8'h00, 5, 1, 8'hA5, 0, 1, k2);
        issue(1, 0, 16'h5678, 8'hC3, 5, 0, 8'h00, 0, 1, k3);
        chk("b2b_gap_1", k2 - k1, 4);
        chk("b2b_gap_2", k3 - k2, 4);
        drain();

        // reset during T1 of a write
        issue(1, 0, 16'hAAAA, 8'h55, 0, 0, 8'h00, 0, 0, k);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_wr_before", mem_wr, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_wr_drop", mem_wr, 0);
        chk("rst_mid_t_state", t_state, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("rst_mid_no_rsp", rsp_valid, 0);

        mem_rdata = 8'h77;
        issue(0, 0, 16'h0042, 8'h00, 5, 1, 8'h77, 0, 1, k);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
